// File: rtl/apb_pkg.sv
// Shared definitions for the 8-bit APB link: FSM state type, bus widths,
// and a helper for sizing the wait counter.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    // Counter width able to hold 0..t; at least one bit so TIMEOUT=0 still builds.
    function automatic int cnt_width(input int t);
        return (t <= 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
interface apb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              pselx;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  pready, prdata
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output pready, prdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter. o_expired is high while the counter sits on
// its last allowed value, so the caller aborts on exactly the TIMEOUT-th cycle.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled wait cycles; clear has priority; hold at TIMEOUT instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign o_expired = 1'b0;
        end else begin : g_timeout
            assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_master.sv
// APB requester: takes single commands on a valid/ready port, runs
// SETUP/ACCESS on the bus, and reports completion or timeout on a
// one-cycle response strobe.
module apb_master
    import apb_pkg::*;
#(
    parameter int DATA_W  = APB_DATA_W,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    apb_if.master             apb
);

    apb_state_t        r_state;
    logic              r_pselx;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_timeout;

    logic w_cmd_ready;
    logic w_accept;
    logic w_wait;
    logic w_expired;

    // Ready in IDLE, or in the completing ACCESS cycle so commands can chain.
    assign w_cmd_ready = !preset &&
                         ((r_state == IDLE) || ((r_state == ACCESS) && apb.pready));
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_wait      = (r_state == ACCESS) && !apb.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (pclk),
        .rst       (preset),
        .i_clr     (w_accept),
        .i_en      (w_wait),
        .o_expired (w_expired)
    );

    // Transfer sequencer: all bus and response outputs are registered here.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= IDLE;
            r_pselx       <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_wdata;
                        r_pselx   <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : apb.prdata;
                        r_penable     <= 1'b0;
                        if (w_accept) begin
                            // Back-to-back: select stays high into the next SETUP.
                            r_pwrite <= cmd_write;
                            r_paddr  <= cmd_addr;
                            r_pwdata <= cmd_wdata;
                            r_state  <= SETUP;
                        end else begin
                            r_pselx <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (w_expired) begin
                        r_pselx       <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_pselx   <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;

    assign apb.pselx   = r_pselx;
    assign apb.penable = r_penable;
    assign apb.pwrite  = r_pwrite;
    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a small behavioural completer that can
// insert wait states or hold pready low forever.
module tb_apb_master;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              pclk;
    logic              preset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;

    apb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .apb         (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Completer model: register memory, wait_n wait states per transfer, or stuck low.
    logic [DATA_W-1:0] mem [256];
    int                acc_cnt;
    int                wait_n;
    logic              stuck;
    logic              mem_clr;

    assign bus.pready = bus.pselx && bus.penable && !stuck && (acc_cnt >= wait_n);
    assign bus.prdata = mem[bus.paddr];

    always_ff @(posedge pclk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            acc_cnt <= 0;
        end else begin
            if (bus.pselx && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
            else                                         acc_cnt <= 0;
            if (bus.pselx && bus.penable && bus.pready && bus.pwrite)
                mem[bus.paddr] <= bus.pwdata;
        end
    end

    int n_total;
    int n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer from IDLE with cycle-by-cycle checks through the response.
    task automatic xfer(input string tag, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input int nwait, input logic to,
                        input logic [7:0] exp_rd);
        int n_acc;
        n_acc  = to ? TIMEOUT : nwait + 1;
        wait_n = nwait;
        stuck  = to;
        chk({tag, ":idle_rdy"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk({tag, ":setup_sel"}, 32'(bus.pselx), 32'd1);
        chk({tag, ":setup_en"},  32'(bus.penable), 32'd0);
        chk({tag, ":setup_rdy"}, 32'(cmd_ready), 32'd0);
        chk({tag, ":paddr"},     32'(bus.paddr), 32'(a));
        chk({tag, ":pwrite"},    32'(bus.pwrite), 32'(w));
        if (w) chk({tag, ":pwdata"}, 32'(bus.pwdata), 32'(d));
        for (int i = 0; i < n_acc; i++) begin
            @(negedge pclk);
            chk({tag, ":acc_sel"},   32'(bus.pselx), 32'd1);
            chk({tag, ":acc_en"},    32'(bus.penable), 32'd1);
            chk({tag, ":acc_addr"},  32'(bus.paddr), 32'(a));
            chk({tag, ":acc_rdy"},   32'(cmd_ready), 32'((i == n_acc - 1) && !to));
            chk({tag, ":acc_rspv"},  32'(rsp_valid), 32'd0);
        end
        @(negedge pclk);
        chk({tag, ":end_sel"}, 32'(bus.pselx), 32'd0);
        chk({tag, ":end_en"},  32'(bus.penable), 32'd0);
        chk({tag, ":rspv"},    32'(rsp_valid), 32'd1);
        chk({tag, ":rspto"},   32'(rsp_timeout), 32'(to));
        chk({tag, ":rdata"},   32'(rsp_rdata), 32'(exp_rd));
        stuck = 1'b0;
        @(negedge pclk);
        chk({tag, ":rspv_off"}, 32'(rsp_valid), 32'd0);
        chk({tag, ":rdata_hold"}, 32'(rsp_rdata), 32'(exp_rd));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":sel"},  32'(bus.pselx), 32'd0);
        chk({tag, ":en"},   32'(bus.penable), 32'd0);
        chk({tag, ":wr"},   32'(bus.pwrite), 32'd0);
        chk({tag, ":addr"}, 32'(bus.paddr), 32'd0);
        chk({tag, ":wd"},   32'(bus.pwdata), 32'd0);
        chk({tag, ":rspv"}, 32'(rsp_valid), 32'd0);
        chk({tag, ":rd"},   32'(rsp_rdata), 32'd0);
        chk({tag, ":to"},   32'(rsp_timeout), 32'd0);
        chk({tag, ":rdy"},  32'(cmd_ready), 32'd0);
    endtask

    int rsp_cnt;
    logic [7:0] b2b_d [4];

    initial begin
        n_total = 0; n_bad = 0;
        preset = 1'b1; mem_clr = 1'b1; stuck = 1'b0; wait_n = 0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(negedge pclk);
        chk_all_zero("rst");
        preset = 1'b0; mem_clr = 1'b0;
        @(negedge pclk);
        chk("rst_rel_rdy", 32'(cmd_ready), 32'd1);

        // Zero-wait write, readback, waited read, timeout.
        xfer("wr03", 1'b1, 8'h03, 8'hA5, 0, 1'b0, 8'h00);
        xfer("rd03", 1'b0, 8'h03, 8'h00, 0, 1'b0, 8'hA5);
        xfer("wr05", 1'b1, 8'h05, 8'h3C, 0, 1'b0, 8'h00);
        xfer("rd05w4", 1'b0, 8'h05, 8'h00, 4, 1'b0, 8'h3C);
        xfer("tmo07", 1'b0, 8'h07, 8'h00, 0, 1'b1, 8'h00);

        // Reset held 3 cycles in the middle of a stalled ACCESS.
        stuck = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h02;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        chk("midrst_pre_en", 32'(bus.penable), 32'd1);
        preset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk_all_zero("midrst");
        end
        preset = 1'b0; stuck = 1'b0;
        @(negedge pclk);
        chk("midrst_post_rspv", 32'(rsp_valid), 32'd0);
        chk("midrst_post_sel",  32'(bus.pselx), 32'd0);
        xfer("postrst_wr", 1'b1, 8'h06, 8'h5A, 0, 1'b0, 8'h00);
        xfer("postrst_rd", 1'b0, 8'h06, 8'h00, 1, 1'b0, 8'h5A);

        // Reset coinciding with the completing pready: no response.
        wait_n = 2;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h03;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rstrdy_pready", 32'(bus.pready), 32'd1);
        preset = 1'b1;
        @(negedge pclk);
        chk("rstrdy_rspv", 32'(rsp_valid), 32'd0);
        chk("rstrdy_sel",  32'(bus.pselx), 32'd0);
        chk("rstrdy_rd",   32'(rsp_rdata), 32'd0);
        preset = 1'b0; wait_n = 0;
        @(negedge pclk);
        chk("rstrdy_rspv2", 32'(rsp_valid), 32'd0);

        // Four back-to-back writes with cmd_valid held high.
        b2b_d[0] = 8'h11; b2b_d[1] = 8'h22; b2b_d[2] = 8'h33; b2b_d[3] = 8'h44;
        rsp_cnt = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = b2b_d[0];
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            if (rsp_valid) rsp_cnt++;
            chk("b2b_setup_sel", 32'(bus.pselx), 32'd1);
            chk("b2b_setup_en",  32'(bus.penable), 32'd0);
            chk("b2b_setup_addr", 32'(bus.paddr), 32'(k));
            chk("b2b_setup_wd",  32'(bus.pwdata), 32'(b2b_d[k]));
            chk("b2b_setup_rspv", 32'(rsp_valid), 32'(k > 0));
            if (k < 3) begin
                cmd_addr = 8'(k + 1); cmd_wdata = b2b_d[k + 1];
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge pclk);
            if (rsp_valid) rsp_cnt++;
            chk("b2b_acc_sel", 32'(bus.pselx), 32'd1);
            chk("b2b_acc_en",  32'(bus.penable), 32'd1);
            chk("b2b_acc_rdy", 32'(cmd_ready), 32'd1);
        end
        @(negedge pclk);
        if (rsp_valid) rsp_cnt++;
        chk("b2b_end_sel", 32'(bus.pselx), 32'd0);
        chk("b2b_rsp_cnt", 32'(rsp_cnt), 32'd4);
        @(negedge pclk);
        for (int k = 0; k < 4; k++) begin
            xfer("b2b_rb", 1'b0, 8'(k), 8'h00, 0, 1'b0, b2b_d[k]);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
